branch_resolve_bht: RTL and testbench

//  Parametrised successor of the execute-stage branch unit. Resolves conditional branches from the

---
 rtl/branch_resolve_bht.sv | 146 ++++++++++++++
 tb/tb_branch_resolve_bht.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_bht.sv
// Execute-stage branch resolution: operand-based condition evaluation, JAL/JALR targets,
// registered redirect/exception pulses, a 2-bit-counter BHT read by fetch, and statistics.
module branch_resolve_bht #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BHT_DEPTH = 64,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  fe_pc,
  output logic             fe_pred_taken,
  input  logic             ex_valid,
  input  logic [6:0]       ex_opcode,
  input  logic [2:0]       ex_func3,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_rs1,
  input  logic [XLEN-1:0]  ex_rs2,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic             ex_pred_taken,
  output logic [XLEN-1:0]  ex_link,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             misalign_exc,
  output logic             illegal_br,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

  typedef enum logic [1:0] {OP_NONE, OP_BR, OP_JAL, OP_JALR} op_e;

  op_e              op;
  logic             cond_taken;
  logic             func3_bad;
  logic             accept;
  logic             is_br;
  logic             taken;
  logic             mispred;
  logic             want_redirect;
  logic             misalign;
  logic [XLEN-1:0]  jalr_sum;
  logic [XLEN-1:0]  target;
  logic [IDX_W-1:0] ex_idx;
  logic [IDX_W-1:0] fe_idx;
  logic [1:0]       bht_cur;
  logic             bht_we;
  logic             unused_bits;

  logic             redirect_valid_d, redirect_valid_q;
  logic [XLEN-1:0]  redirect_pc_d, redirect_pc_q;
  logic             misalign_exc_d, misalign_exc_q;
  logic             illegal_br_d, illegal_br_q;
  logic [CNT_W-1:0] br_count_d, br_count_q;
  logic [CNT_W-1:0] mispred_count_d, mispred_count_q;
  logic [1:0]       bht_wdata_d;
  logic [1:0]       bht_q [BHT_DEPTH];

  assign ex_idx        = ex_pc[IDX_W+1:2];
  assign fe_idx        = fe_pc[IDX_W+1:2];
  assign fe_pred_taken = bht_q[fe_idx][1];
  assign ex_link       = ex_pc + XLEN'(4);
  assign unused_bits   = ^{fe_pc[XLEN-1:IDX_W+2], fe_pc[1:0], jalr_sum[0]};

  always_comb begin
    op = OP_NONE;
    case (ex_opcode)
      7'b1100011: op = OP_BR;
      7'b1101111: op = OP_JAL;
      7'b1100111: op = OP_JALR;
      default:    op = OP_NONE;
    endcase

    cond_taken = 1'b0;
    func3_bad  = 1'b0;
    case (ex_func3)
      3'b000:  cond_taken = (ex_rs1 == ex_rs2);
      3'b001:  cond_taken = (ex_rs1 != ex_rs2);
      3'b100:  cond_taken = ($signed(ex_rs1) <  $signed(ex_rs2));
      3'b101:  cond_taken = ($signed(ex_rs1) >= $signed(ex_rs2));
      3'b110:  cond_taken = (ex_rs1 <  ex_rs2);
      3'b111:  cond_taken = (ex_rs1 >= ex_rs2);
      default: func3_bad  = 1'b1;
    endcase

    // A redirect in flight means this instruction is on the wrong path.
    accept        = ex_valid && (op != OP_NONE) && !redirect_valid_q;
    is_br         = (op == OP_BR);
    taken         = is_br ? cond_taken : 1'b1;
    jalr_sum      = ex_rs1 + ex_imm;
    target        = (op == OP_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : (ex_pc + ex_imm);
    mispred       = is_br && (taken != ex_pred_taken);
    want_redirect = is_br ? mispred : 1'b1;
    misalign      = taken && target[1];

    redirect_valid_d = accept && want_redirect && !misalign;
    redirect_pc_d    = redirect_pc_q;
    if (accept && want_redirect) begin
      redirect_pc_d = taken ? target : ex_link;
    end
    misalign_exc_d  = accept && misalign;
    illegal_br_d    = accept && is_br && func3_bad;
    br_count_d      = br_count_q + CNT_W'(accept && is_br);
    mispred_count_d = mispred_count_q + CNT_W'(accept && mispred);

    bht_we  = accept && is_br;
    bht_cur = bht_q[ex_idx];
    if (cond_taken) begin
      bht_wdata_d = (bht_cur == 2'b11) ? bht_cur : bht_cur + 2'b01;
    end else begin
      bht_wdata_d = (bht_cur == 2'b00) ? bht_cur : bht_cur - 2'b01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      misalign_exc_q   <= 1'b0;
      illegal_br_q     <= 1'b0;
      br_count_q       <= '0;
      mispred_count_q  <= '0;
      for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else begin
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      misalign_exc_q   <= misalign_exc_d;
      illegal_br_q     <= illegal_br_d;
      br_count_q       <= br_count_d;
      mispred_count_q  <= mispred_count_d;
      if (bht_we) begin
        bht_q[ex_idx] <= bht_wdata_d;
      end
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign misalign_exc   = misalign_exc_q;
  assign illegal_br     = illegal_br_q;
  assign br_count       = br_count_q;
  assign mispred_count  = mispred_count_q;

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Scoreboard bench for branch_resolve_bht: a reference model pushes expected pulses per driven
// instruction; they are popped and compared one cycle later. A CNT_W=4 copy exercises wrap.
module tb_branch_resolve_bht;

  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ALU  = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fe_pc;
  logic        ex_valid;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_func3;
  logic [31:0] ex_pc, ex_rs1, ex_rs2, ex_imm;
  logic        ex_pred_taken;

  logic        fe_pred_taken, redirect_valid, misalign_exc, illegal_br;
  logic [31:0] ex_link, redirect_pc, br_count, mispred_count;
  logic        s_fe_pred, s_rv, s_mis, s_ill;
  logic [31:0] s_link, s_rpc;
  logic [3:0]  s_br, s_mp;

  always #5 clk = ~clk;

  branch_resolve_bht #(.XLEN(32), .BHT_DEPTH(64), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .fe_pc(fe_pc), .fe_pred_taken(fe_pred_taken),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_func3(ex_func3), .ex_pc(ex_pc),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_imm(ex_imm), .ex_pred_taken(ex_pred_taken),
    .ex_link(ex_link), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .misalign_exc(misalign_exc), .illegal_br(illegal_br), .br_count(br_count),
    .mispred_count(mispred_count)
  );

  branch_resolve_bht #(.XLEN(32), .BHT_DEPTH(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .fe_pc(fe_pc), .fe_pred_taken(s_fe_pred),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_func3(ex_func3), .ex_pc(ex_pc),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_imm(ex_imm), .ex_pred_taken(ex_pred_taken),
    .ex_link(s_link), .redirect_valid(s_rv), .redirect_pc(s_rpc),
    .misalign_exc(s_mis), .illegal_br(s_ill), .br_count(s_br), .mispred_count(s_mp)
  );

  typedef struct packed {
    logic        rv;
    logic        chk_rpc;
    logic [31:0] rpc;
    logic        mis;
    logic        ill;
  } exp_t;

  typedef struct {
    logic        v;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] pc, a, b, imm;
    logic        pred;
  } step_t;

  exp_t        sbq[$];
  logic [1:0]  m_bht [64];
  logic [31:0] m_br, m_mp;
  logic        m_rv;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic step_t mk(input logic v, input logic [6:0] op, input logic [2:0] f3,
                               input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] imm, input logic pred);
    step_t s;
    s.v = v; s.op = op; s.f3 = f3; s.pc = pc; s.a = a; s.b = b; s.imm = imm; s.pred = pred;
    return s;
  endfunction

  function automatic step_t idle();
    return mk(1'b0, OP_B, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
  endfunction

  task automatic m_reset();
    foreach (m_bht[i]) m_bht[i] = 2'b01;
    m_br = '0;
    m_mp = '0;
    m_rv = 1'b0;
    sbq.delete();
  endtask

  // Drives one instruction at the falling edge and pushes what the model expects after the next rise.
  task automatic issue(input step_t s);
    exp_t        e;
    logic        tk, ill, isb, isj;
    logic [31:0] tgt;
    int          idx;
    @(negedge clk);
    ex_valid = s.v; ex_opcode = s.op; ex_func3 = s.f3; ex_pc = s.pc;
    ex_rs1 = s.a; ex_rs2 = s.b; ex_imm = s.imm; ex_pred_taken = s.pred;
    e   = '0;
    isb = (s.op == OP_B);
    isj = (s.op == OP_JAL) || (s.op == OP_JALR);
    if (s.v && (isb || isj) && !m_rv) begin
      if (isb) begin
        tk = 1'b0; ill = 1'b0;
        case (s.f3)
          3'd0: tk = (s.a == s.b);
          3'd1: tk = (s.a != s.b);
          3'd4: tk = ($signed(s.a) < $signed(s.b));
          3'd5: tk = !($signed(s.a) < $signed(s.b));
          3'd6: tk = (s.a < s.b);
          3'd7: tk = !(s.a < s.b);
          default: ill = 1'b1;
        endcase
        tgt   = s.pc + s.imm;
        idx   = int'(s.pc[7:2]);
        m_br  = m_br + 1;
        e.ill = ill;
        e.mis = tk && tgt[1];
        if (tk && m_bht[idx] != 2'b11) m_bht[idx] = m_bht[idx] + 2'b01;
        else if (!tk && m_bht[idx] != 2'b00) m_bht[idx] = m_bht[idx] - 2'b01;
        if (tk != s.pred) begin
          m_mp = m_mp + 1;
          if (!e.mis) begin
            e.rv = 1'b1; e.chk_rpc = 1'b1;
            e.rpc = tk ? tgt : s.pc + 32'd4;
          end
        end
      end else begin
        tgt = (s.op == OP_JALR) ? ((s.a + s.imm) & 32'hFFFF_FFFE) : (s.pc + s.imm);
        e.mis = tgt[1]; e.rv = !tgt[1]; e.chk_rpc = 1'b1; e.rpc = tgt;
      end
    end
    m_rv = e.rv;
    sbq.push_back(e);
    #1;
  endtask

  task automatic collect(output exp_t e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_empty got 0 entries required >=1");
      e = '0;
    end else begin
      e = sbq.pop_front();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ex_valid = 1'b0; ex_opcode = '0; ex_func3 = '0; ex_pc = '0;
    ex_rs1 = '0; ex_rs2 = '0; ex_imm = '0; ex_pred_taken = 1'b0; fe_pc = 32'h40;
    m_reset();
    #3;
    n_cmp++;
    if ({redirect_valid, misalign_exc, illegal_br} !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags got %b required 000", {redirect_valid, misalign_exc, illegal_br});
    end
    n_cmp++;
    if (redirect_pc !== 32'h0) begin
      n_bad++; $display("FAIL reset_rpc got %h required 0", redirect_pc);
    end
    n_cmp++;
    if (br_count !== 32'h0 || mispred_count !== 32'h0 || s_br !== 4'h0 || s_mp !== 4'h0) begin
      n_bad++; $display("FAIL reset_counts got %0d/%0d required 0/0", br_count, mispred_count);
    end
    n_cmp++;
    if (fe_pred_taken !== 1'b0) begin
      n_bad++; $display("FAIL reset_fe_pred got %b required 0", fe_pred_taken);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_beq();
    exp_t e;
    issue(mk(1'b1, OP_B, 3'd0, 32'h100, 32'd5, 32'd5, 32'h20, 1'b0));
    collect(e);
    n_cmp++;
    if ({redirect_valid, misalign_exc, illegal_br} !== {e.rv, e.mis, e.ill} || redirect_valid !== 1'b1) begin
      n_bad++; $display("FAIL beq_flags got %b required 100", {redirect_valid, misalign_exc, illegal_br});
    end
    n_cmp++;
    if (redirect_pc !== 32'h120) begin
      n_bad++; $display("FAIL beq_rpc got %h required 00000120", redirect_pc);
    end
    n_cmp++;
    if (br_count !== 32'd1 || mispred_count !== 32'd1) begin
      n_bad++; $display("FAIL beq_counts got %0d/%0d required 1/1", br_count, mispred_count);
    end
    issue(idle());
    collect(e);
    n_cmp++;
    if (redirect_valid !== 1'b0) begin
      n_bad++; $display("FAIL beq_pulse_end got %b required 0", redirect_valid);
    end
  endtask

  task automatic test_conditions();
    step_t s[$];
    exp_t  e;
    s.push_back(mk(1'b1, OP_B, 3'd4, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b1)); s.push_back(idle());
    s.push_back(mk(1'b1, OP_B, 3'd6, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b1)); s.push_back(idle());
    s.push_back(mk(1'b1, OP_B, 3'd1, 32'h200, 32'd3, 32'd3, 32'h40, 1'b0));        s.push_back(idle());
    s.push_back(mk(1'b1, OP_B, 3'd5, 32'h200, 32'd1, 32'hFFFF_FFFF, 32'h40, 1'b0)); s.push_back(idle());
    s.push_back(mk(1'b1, OP_B, 3'd7, 32'h200, 32'd1, 32'hFFFF_FFFF, 32'h40, 1'b0)); s.push_back(idle());
    s.push_back(mk(1'b1, OP_B, 3'd0, 32'h200, 32'd7, 32'd8, 32'h40, 1'b1));        s.push_back(idle());
    foreach (s[i]) begin
      issue(s[i]);
      collect(e);
      n_cmp++;
      if ({redirect_valid, misalign_exc, illegal_br} !== {e.rv, e.mis, e.ill}) begin
        n_bad++; $display("FAIL cond_flags[%0d] got %b required %b", i,
                          {redirect_valid, misalign_exc, illegal_br}, {e.rv, e.mis, e.ill});
      end
      if (e.chk_rpc) begin
        n_cmp++;
        if (redirect_pc !== e.rpc) begin
          n_bad++; $display("FAIL cond_rpc[%0d] got %h required %h", i, redirect_pc, e.rpc);
        end
      end
      n_cmp++;
      if (br_count !== m_br || mispred_count !== m_mp) begin
        n_bad++; $display("FAIL cond_counts[%0d] got %0d/%0d required %0d/%0d", i,
                          br_count, mispred_count, m_br, m_mp);
      end
    end
  endtask

  task automatic test_bht();
    step_t s[$];
    exp_t  e;
    logic  fe_exp [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    fe_pc = 32'h10;
    repeat (3) s.push_back(mk(1'b1, OP_B, 3'd0, 32'h10, 32'd1, 32'd1, 32'h4, 1'b1));
    s.push_back(idle());
    s.push_back(mk(1'b1, OP_B, 3'd1, 32'h10, 32'd1, 32'd1, 32'h4, 1'b1));
    s.push_back(idle());
    s.push_back(mk(1'b1, OP_B, 3'd0, 32'h10, 32'd1, 32'd2, 32'h4, 1'b1));
    s.push_back(idle());
    foreach (s[i]) begin
      issue(s[i]);
      n_cmp++;
      if (fe_pred_taken !== fe_exp[i]) begin
        n_bad++; $display("FAIL bht_read[%0d] got %b required %b", i, fe_pred_taken, fe_exp[i]);
      end
      collect(e);
      n_cmp++;
      if ({redirect_valid, misalign_exc, illegal_br} !== {e.rv, e.mis, e.ill} ||
          (e.chk_rpc && redirect_pc !== e.rpc)) begin
        n_bad++; $display("FAIL bht_out[%0d] got %b/%h required %b/%h", i,
                          {redirect_valid, misalign_exc, illegal_br}, redirect_pc, {e.rv, e.mis, e.ill}, e.rpc);
      end
    end
  endtask

  task automatic test_jump();
    exp_t e;
    issue(mk(1'b1, OP_JALR, 3'd0, 32'h500, 32'h1003, 32'd0, 32'd0, 1'b0));
    collect(e);
    n_cmp++;
    if ({redirect_valid, misalign_exc, illegal_br} !== 3'b010 || e.mis !== 1'b1) begin
      n_bad++; $display("FAIL jalr_flags got %b required 010", {redirect_valid, misalign_exc, illegal_br});
    end
    n_cmp++;
    if (redirect_pc !== 32'h1002) begin
      n_bad++; $display("FAIL jalr_rpc got %h required 00001002", redirect_pc);
    end
    issue(mk(1'b1, OP_JAL, 3'd0, 32'h300, 32'd0, 32'd0, 32'hFFFF_FFF8, 1'b0));
    n_cmp++;
    if (ex_link !== 32'h304) begin
      n_bad++; $display("FAIL jal_link got %h required 00000304", ex_link);
    end
    collect(e);
    n_cmp++;
    if (redirect_valid !== 1'b1 || misalign_exc !== 1'b0 || redirect_pc !== 32'h2F8) begin
      n_bad++; $display("FAIL jal_redirect got %b/%h required 1/000002f8", redirect_valid, redirect_pc);
    end
    issue(idle());
    collect(e);
  endtask

  task automatic test_shadow();
    step_t s[$];
    exp_t  e;
    fe_pc = 32'h20;
    s.push_back(mk(1'b1, OP_B, 3'd0, 32'h40, 32'd9, 32'd9, 32'h10, 1'b0));
    s.push_back(mk(1'b1, OP_B, 3'd0, 32'h20, 32'd9, 32'd9, 32'h10, 1'b0));
    s.push_back(mk(1'b1, OP_ALU, 3'd0, 32'h24, 32'd0, 32'd0, 32'h10, 1'b0));
    s.push_back(mk(1'b1, OP_B, 3'd2, 32'h28, 32'd0, 32'd0, 32'h10, 1'b0));
    s.push_back(mk(1'b1, OP_B, 3'd3, 32'h2C, 32'd0, 32'd0, 32'h10, 1'b1));
    s.push_back(mk(1'b1, OP_JAL, 3'd0, 32'h30, 32'd0, 32'd0, 32'h10, 1'b0));
    s.push_back(idle());
    foreach (s[i]) begin
      issue(s[i]);
      collect(e);
      n_cmp++;
      if ({redirect_valid, misalign_exc, illegal_br} !== {e.rv, e.mis, e.ill} ||
          (e.chk_rpc && redirect_pc !== e.rpc)) begin
        n_bad++; $display("FAIL shadow_out[%0d] got %b/%h required %b/%h", i,
                          {redirect_valid, misalign_exc, illegal_br}, redirect_pc, {e.rv, e.mis, e.ill}, e.rpc);
      end
      n_cmp++;
      if (br_count !== m_br || mispred_count !== m_mp) begin
        n_bad++; $display("FAIL shadow_counts[%0d] got %0d/%0d required %0d/%0d", i,
                          br_count, mispred_count, m_br, m_mp);
      end
    end
    n_cmp++;
    if (fe_pred_taken !== 1'b0) begin
      n_bad++; $display("FAIL shadow_bht got %b required 0", fe_pred_taken);
    end
  endtask

  task automatic test_back_to_back();
    step_t s[$];
    exp_t  e;
    s.push_back(mk(1'b1, OP_B, 3'd0, 32'h0, 32'd1, 32'd1, 32'h6, 1'b1));
    s.push_back(mk(1'b1, OP_B, 3'd0, 32'h4, 32'd1, 32'd1, 32'h6, 1'b0));
    s.push_back(mk(1'b1, OP_B, 3'd2, 32'h8, 32'd1, 32'd1, 32'h8, 1'b0));
    s.push_back(mk(1'b1, OP_B, 3'd2, 32'hC, 32'd1, 32'd1, 32'h8, 1'b0));
    s.push_back(mk(1'b1, OP_B, 3'd1, 32'h10, 32'd1, 32'd2, 32'h8, 1'b1));
    s.push_back(mk(1'b1, OP_B, 3'd6, 32'h14, 32'd1, 32'd2, 32'h8, 1'b1));
    s.push_back(mk(1'b1, OP_B, 3'd7, 32'h18, 32'd1, 32'd2, 32'h8, 1'b0));
    s.push_back(idle());
    foreach (s[i]) begin
      issue(s[i]);
      collect(e);
      n_cmp++;
      if ({redirect_valid, misalign_exc, illegal_br} !== {e.rv, e.mis, e.ill} ||
          (e.chk_rpc && redirect_pc !== e.rpc)) begin
        n_bad++; $display("FAIL b2b_out[%0d] got %b/%h required %b/%h", i,
                          {redirect_valid, misalign_exc, illegal_br}, redirect_pc, {e.rv, e.mis, e.ill}, e.rpc);
      end
      n_cmp++;
      if (br_count !== m_br || mispred_count !== m_mp) begin
        n_bad++; $display("FAIL b2b_counts[%0d] got %0d/%0d required %0d/%0d", i,
                          br_count, mispred_count, m_br, m_mp);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    issue(mk(1'b1, OP_B, 3'd0, 32'h60, 32'd2, 32'd2, 32'h10, 1'b0));
    collect(e);
    n_cmp++;
    if (redirect_valid !== 1'b1 || e.rv !== 1'b1) begin
      n_bad++; $display("FAIL arst_pre got %b required 1", redirect_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (redirect_valid !== 1'b0 || br_count !== 32'h0 || mispred_count !== 32'h0) begin
      n_bad++; $display("FAIL arst_drop got %b/%0d/%0d required 0/0/0", redirect_valid, br_count, mispred_count);
    end
    m_reset();
    @(negedge clk);
    ex_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_wrap();
    exp_t e;
    for (int unsigned i = 0; i < 17; i++) begin
      issue(mk(1'b1, OP_B, 3'd0, 32'(i * 4), 32'd3, 32'd3, 32'h20, 1'b0));
      collect(e);
      issue(idle());
      collect(e);
      n_cmp++;
      if (s_br !== m_br[3:0] || s_mp !== m_mp[3:0] || br_count !== m_br) begin
        n_bad++; $display("FAIL wrap[%0d] got %0d/%0d required %0d/%0d", i, s_br, s_mp, m_br[3:0], m_mp[3:0]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_beq();
    test_conditions();
    test_bht();
    test_jump();
    test_shadow();
    test_back_to_back();
    test_async_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
